// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BUSY_TMO_DEF = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered count/full/empty and a
// combinational head-of-queue read port.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  byte_t         din,
    output byte_t         dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned CW = AW + 1;

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;
    logic [CW-1:0]   count_nxt;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus Tx_WR/Tx_BUSY handshake engine feeding uart_transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned BUSY_TMO = BUSY_TMO_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_en,
    input  byte_t         wr_data,
    input  logic          clr_err,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          tmo,
    output byte_t         Tx_DATA,
    output logic          Tx_WR,
    output logic          Tx_EN,
    input  logic          Tx_BUSY
);

    localparam int unsigned TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

    tx_state_e       state;
    tx_state_e       state_nxt;
    logic [TW-1:0]   tmo_cnt;
    byte_t           fifo_dout;
    logic            issue_c;
    logic            tmo_set_c;
    logic            tmo_inc_c;

    assign Tx_EN = enable;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (issue_c),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; enable only gates the start of a new byte.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && !empty && !Tx_BUSY) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (Tx_BUSY) begin
                    state_nxt = ST_WAIT_LO;
                end else if (tmo_cnt == TW'(BUSY_TMO - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!Tx_BUSY) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Control strobes decoded from the current transition.
    always_comb begin
        issue_c   = 1'b0;
        tmo_set_c = 1'b0;
        tmo_inc_c = 1'b0;
        if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
            issue_c = 1'b1;
        end
        if (state == ST_WAIT_HI && state_nxt == ST_IDLE) begin
            tmo_set_c = 1'b1;
        end
        if (state == ST_WAIT_HI && state_nxt == ST_WAIT_HI) begin
            tmo_inc_c = 1'b1;
        end
    end

    // Cycles spent in WAIT_HI without seeing Tx_BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (tmo_inc_c) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Registered transmitter strobe and data; data holds until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Tx_WR   <= 1'b0;
            Tx_DATA <= '0;
        end else begin
            Tx_WR <= issue_c;
            if (issue_c) begin
                Tx_DATA <= fifo_dout;
            end
        end
    end

    // Sticky error flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (tmo_set_c) begin
                tmo <= 1'b1;
            end else if (clr_err) begin
                tmo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench: transmitter stub, queue-based scoreboard, vector table
// for the overflow sequence, directed corner cases and a randomized run.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AW       = 4;
    localparam int unsigned BUSY_TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_err;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          tmo;
    logic [7:0]    Tx_DATA;
    logic          Tx_WR;
    logic          Tx_EN;
    logic          Tx_BUSY;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .BUSY_TMO (BUSY_TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_err (clr_err),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .tmo     (tmo),
        .Tx_DATA (Tx_DATA),
        .Tx_WR   (Tx_WR),
        .Tx_EN   (Tx_EN),
        .Tx_BUSY (Tx_BUSY)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  data;
        logic        clr;
        int unsigned cnt;
        logic        full;
        logic        empty;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    int npass = 0;
    int ntot  = 0;

    // Reference model: bytes accepted but not yet issued, sticky overflow.
    logic [7:0] exp_q [$];
    logic       exp_ovf;
    int         cyc;
    int         last_wr_cyc;
    int         n_pulses;
    int         max_cnt;
    logic       prev_wr;

    // Transmitter stub controls.
    bit         never_busy;
    bit         rand_stub;
    int         rise_dly;
    int         frame_len;
    bit         pend;
    int         rise_ctr;
    int         hold_ctr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample inputs the edge sees, advance model and stub, compare.
    task automatic tick();
        logic       w;
        logic [7:0] d;
        logic       c;
        bit         full_b;
        w = wr_en;
        d = wr_data;
        c = clr_err;
        @(posedge clk);
        #1;
        cyc++;
        full_b = (exp_q.size() == DEPTH);
        if (Tx_WR) begin
            n_pulses++;
            check("strobe_while_busy", 32'(Tx_BUSY), 32'(0));
            check("strobe_width", 32'(prev_wr), 32'(0));
            if (last_wr_cyc >= 0) begin
                check("strobe_spacing", 32'((cyc - last_wr_cyc) >= 4), 32'(1));
            end
            last_wr_cyc = cyc;
            check("strobe_has_data", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                check("tx_data_order", 32'(Tx_DATA), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (w && !full_b) begin
            exp_q.push_back(d);
        end
        if (w && full_b) begin
            exp_ovf = 1'b1;
        end else if (c) begin
            exp_ovf = 1'b0;
        end
        check("count", 32'(count), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("tx_en", 32'(Tx_EN), 32'(enable));
        if (int'(count) > max_cnt) begin
            max_cnt = int'(count);
        end
        prev_wr = Tx_WR;
        if (Tx_WR && !never_busy) begin
            if (rand_stub) begin
                rise_dly  = int'($urandom_range(0, 2));
                frame_len = int'($urandom_range(1, 8));
            end
            pend     = 1'b1;
            rise_ctr = rise_dly;
        end
        if (pend) begin
            if (rise_ctr == 0) begin
                Tx_BUSY  = 1'b1;
                hold_ctr = frame_len;
                pend     = 1'b0;
            end else begin
                rise_ctr--;
            end
        end else if (Tx_BUSY) begin
            if (hold_ctr == 0) begin
                Tx_BUSY = 1'b0;
            end else begin
                hold_ctr--;
            end
        end
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_ovf     = 1'b0;
        Tx_BUSY     = 1'b0;
        pend        = 1'b0;
        prev_wr     = 1'b0;
        last_wr_cyc = -1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Run until every queued byte has been handed off and the stub is idle.
    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || Tx_BUSY || pend) && k < 600) begin
            tick();
            k++;
        end
        check("drain_done", 32'(exp_q.size()), 32'(0));
        repeat (6) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vec[i] = '{1'b1, 8'(8'h40 + i), 1'b0, 32'(i + 1), (i == 15), 1'b0, 1'b0};
        end
        vec[16] = '{1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b0, 1'b1};
        vec[17] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};
        vec[18] = '{1'b1, 8'h77, 1'b1, 16, 1'b1, 1'b0, 1'b1};
        vec[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};
        vec[20] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b0};

        reset      = 1'b1;
        enable     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        clr_err    = 1'b0;
        Tx_BUSY    = 1'b0;
        never_busy = 1'b0;
        rand_stub  = 1'b0;
        rise_dly   = 1;
        frame_len  = 6;
        pend       = 1'b0;
        rise_ctr   = 0;
        hold_ctr   = 0;
        exp_ovf    = 1'b0;
        cyc        = 0;
        last_wr_cyc = -1;
        n_pulses   = 0;
        max_cnt    = 0;
        prev_wr    = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_wr", 32'(Tx_WR), 32'(0));
        check("rst_tx_data", 32'(Tx_DATA), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_full", 32'(full), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_tmo", 32'(tmo), 32'(0));
        reset = 1'b0;

        // Single byte: push at N, strobe from N+1 to N+2.
        enable = 1'b1;
        tick();
        n_pulses = 0;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("single_empty_N", 32'(empty), 32'(0));
        check("single_wr_N", 32'(Tx_WR), 32'(0));
        tick();
        check("single_wr_N1", 32'(Tx_WR), 32'(1));
        check("single_data_N1", 32'(Tx_DATA), 32'(8'hA5));
        tick();
        check("single_wr_N2", 32'(Tx_WR), 32'(0));
        drain();
        check("single_data_hold", 32'(Tx_DATA), 32'(8'hA5));
        check("single_pulses", 32'(n_pulses), 32'(1));

        // Burst of five consecutive pushes.
        n_pulses = 0;
        max_cnt  = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        drain();
        check("burst_pulses", 32'(n_pulses), 32'(5));
        check("burst_peak", 32'(max_cnt == 4 || max_cnt == 5), 32'(1));
        check("burst_count_end", 32'(count), 32'(0));

        // Overflow and sticky-flag clearing with draining disabled.
        enable = 1'b0;
        tick();
        for (int i = 0; i < NVEC; i++) begin
            wr_en = vec[i].wr; wr_data = vec[i].data; clr_err = vec[i].clr;
            tick();
            wr_en = 1'b0; clr_err = 1'b0;
            check("vec_count", 32'(count), 32'(vec[i].cnt));
            check("vec_full", 32'(full), 32'(vec[i].full));
            check("vec_empty", 32'(empty), 32'(vec[i].empty));
            check("vec_ovf", 32'(ovf), 32'(vec[i].ovf));
        end
        n_pulses = 0;
        enable = 1'b1;
        drain();
        check("ovf_drain_pulses", 32'(n_pulses), 32'(16));

        // Timeout: the transmitter never raises Tx_BUSY.
        never_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        tick();
        check("tmo_wr", 32'(Tx_WR), 32'(1));
        check("tmo_data", 32'(Tx_DATA), 32'(8'h3C));
        repeat (4) tick();
        check("tmo_before", 32'(tmo), 32'(0));
        tick();
        check("tmo_set", 32'(tmo), 32'(1));
        check("tmo_count", 32'(count), 32'(0));
        wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        tick();
        check("tmo_idle_reissue", 32'(Tx_WR), 32'(1));
        check("tmo_sticky", 32'(tmo), 32'(1));
        repeat (6) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_clear", 32'(tmo), 32'(0));
        never_busy = 1'b0;

        // Reset while Tx_WR is high.
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        tick();
        check("rst_inflight_pre", 32'(Tx_WR), 32'(1));
        assert_reset();
        check("rst_inflight_wr", 32'(Tx_WR), 32'(0));
        release_reset();

        // Reset during WAIT_LO with three bytes queued.
        rise_dly  = 0;
        frame_len = 20;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        check("rst_mid_queued", 32'(count), 32'(3));
        assert_reset();
        check("rst_mid_wr", 32'(Tx_WR), 32'(0));
        check("rst_mid_count", 32'(count), 32'(0));
        check("rst_mid_empty", 32'(empty), 32'(1));
        release_reset();
        n_pulses = 0;
        repeat (12) tick();
        check("rst_mid_no_wr", 32'(n_pulses), 32'(0));
        rise_dly  = 1;
        frame_len = 5;
        wr_en = 1'b1; wr_data = 8'hD7;
        tick();
        wr_en = 1'b0;
        drain();
        check("rst_mid_new_push", 32'(n_pulses), 32'(1));

        // Push coincident with popping the only entry.
        enable = 1'b0;
        wr_en = 1'b1; wr_data = 8'h91;
        tick();
        wr_en = 1'b0;
        tick();
        n_pulses = 0;
        enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'h92;
        tick();
        wr_en = 1'b0;
        check("simul_wr", 32'(Tx_WR), 32'(1));
        check("simul_data", 32'(Tx_DATA), 32'(8'h91));
        check("simul_count", 32'(count), 32'(1));
        check("simul_empty", 32'(empty), 32'(0));
        drain();
        check("simul_pulses", 32'(n_pulses), 32'(2));

        // Randomized traffic with random transmitter timing.
        rand_stub = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 99) < 35);
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 4) begin
                enable = ~enable;
            end
            tick();
        end
        wr_en   = 1'b0;
        clr_err = 1'b0;
        enable  = 1'b1;
        drain();
        check("rand_tmo", 32'(tmo), 32'(0));
        check("rand_count_end", 32'(count), 32'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
